// File: rtl/epg_rx.sv
// Serial Ethernet frame receiver: hunts preamble/SFD, then deserializes MSB-first DA, SA, length, payload and FCS.
// Payload bytes appear on wr_en one cycle after their last bit; header/FCS fields update together with frame_done.
module epg_rx #(
  parameter int dataWidth = 8,
  parameter int MAX_LEN   = 1500,
  parameter int PRE_MAX   = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 packet,
  input  logic                 packetValid,
  output logic [dataWidth-1:0] data_out,
  output logic                 wr_en,
  output logic [47:0]          dMAC,
  output logic [47:0]          sMAC,
  output logic [15:0]          length,
  output logic [31:0]          FCS,
  output logic                 frame_done,
  output logic                 err,
  output logic [1:0]           err_code
);
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [15:0] PRE_MAX_W = 16'(PRE_MAX);
  localparam logic [15:0] BYTE_TOP  = 16'(dataWidth - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DMAC, S_SMAC, S_LEN, S_DATA, S_FCS, S_DRAIN} state_t;

  state_t               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 prev_q, prev_d;
  logic [46:0]          sh_q, sh_d;
  logic [47:0]          dmac_tmp_q, dmac_tmp_d;
  logic [47:0]          smac_tmp_q, smac_tmp_d;
  logic [15:0]          len_tmp_q, len_tmp_d;
  logic [15:0]          byte_cnt_q, byte_cnt_d;
  logic [dataWidth-1:0] data_out_q, data_out_d;
  logic                 wr_en_q, wr_en_d;
  logic                 frame_done_q, frame_done_d;
  logic                 err_q, err_d;
  logic [1:0]           err_code_q, err_code_d;
  logic [47:0]          dmac_q, dmac_d;
  logic [47:0]          smac_q, smac_d;
  logic [15:0]          length_q, length_d;
  logic [31:0]          fcs_q, fcs_d;
  logic [47:0]          shifted;

  // One shared shifter serves every field; each field takes exactly its own width from the low end.
  assign shifted = {sh_q, packet};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    prev_d       = prev_q;
    sh_d         = sh_q;
    dmac_tmp_d   = dmac_tmp_q;
    smac_tmp_d   = smac_tmp_q;
    len_tmp_d    = len_tmp_q;
    byte_cnt_d   = byte_cnt_q;
    data_out_d   = data_out_q;
    wr_en_d      = 1'b0;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    err_code_d   = 2'd0;
    dmac_d       = dmac_q;
    smac_d       = smac_q;
    length_d     = length_q;
    fcs_d        = fcs_q;

    case (state_q)
      S_IDLE: begin
        if (packetValid) begin
          prev_d  = packet;
          cnt_d   = 16'd1;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (!packetValid) begin
          err_d = 1'b1; err_code_d = 2'd3; state_d = S_IDLE;
        end else if (prev_q && packet) begin
          cnt_d   = 16'd47;
          state_d = S_DMAC;
        end else begin
          prev_d = packet;
          cnt_d  = cnt_q + 16'd1;
          if (cnt_d >= PRE_MAX_W) begin
            err_d = 1'b1; err_code_d = 2'd1; state_d = S_DRAIN;
          end
        end
      end
      S_DMAC, S_SMAC, S_LEN: begin
        if (!packetValid) begin
          err_d = 1'b1; err_code_d = 2'd3; state_d = S_IDLE;
        end else begin
          sh_d  = shifted[46:0];
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd0) begin
            if (state_q == S_DMAC) begin
              dmac_tmp_d = shifted;
              cnt_d      = 16'd47;
              state_d    = S_SMAC;
            end else if (state_q == S_SMAC) begin
              smac_tmp_d = shifted;
              cnt_d      = 16'd15;
              state_d    = S_LEN;
            end else begin
              len_tmp_d = shifted[15:0];
              if (shifted[15:0] > MAX_LEN_W) begin
                err_d = 1'b1; err_code_d = 2'd2; state_d = S_DRAIN;
              end else if (shifted[15:0] == 16'd0) begin
                cnt_d   = 16'd31;
                state_d = S_FCS;
              end else begin
                byte_cnt_d = 16'd0;
                cnt_d      = BYTE_TOP;
                state_d    = S_DATA;
              end
            end
          end
        end
      end
      S_DATA: begin
        if (!packetValid) begin
          err_d = 1'b1; err_code_d = 2'd3; state_d = S_IDLE;
        end else begin
          sh_d  = shifted[46:0];
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd0) begin
            data_out_d = shifted[dataWidth-1:0];
            wr_en_d    = 1'b1;
            byte_cnt_d = byte_cnt_q + 16'd1;
            cnt_d      = BYTE_TOP;
            if (byte_cnt_d == len_tmp_q) begin
              cnt_d   = 16'd31;
              state_d = S_FCS;
            end
          end
        end
      end
      S_FCS: begin
        // The last FCS bit arrives with packetValid already low, so the qualifier is not consulted here.
        sh_d  = shifted[46:0];
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd0) begin
          dmac_d       = dmac_tmp_q;
          smac_d       = smac_tmp_q;
          length_d     = len_tmp_q;
          fcs_d        = shifted[31:0];
          frame_done_d = 1'b1;
          cnt_d        = 16'd0;
          state_d      = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (!packetValid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      prev_q       <= 1'b0;
      sh_q         <= '0;
      dmac_tmp_q   <= '0;
      smac_tmp_q   <= '0;
      len_tmp_q    <= '0;
      byte_cnt_q   <= '0;
      data_out_q   <= '0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
      dmac_q       <= '0;
      smac_q       <= '0;
      length_q     <= '0;
      fcs_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      sh_q         <= sh_d;
      dmac_tmp_q   <= dmac_tmp_d;
      smac_tmp_q   <= smac_tmp_d;
      len_tmp_q    <= len_tmp_d;
      byte_cnt_q   <= byte_cnt_d;
      data_out_q   <= data_out_d;
      wr_en_q      <= wr_en_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      dmac_q       <= dmac_d;
      smac_q       <= smac_d;
      length_q     <= length_d;
      fcs_q        <= fcs_d;
    end
  end

  assign data_out   = data_out_q;
  assign wr_en      = wr_en_q;
  assign dMAC       = dmac_q;
  assign sMAC       = smac_q;
  assign length     = length_q;
  assign FCS        = fcs_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
endmodule
